uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: CLKS_PER_BIT, 16, clock cycles per serial bit; SHALL be an even integer >= 4.
REQ-002 Port: clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: rx  input  1  asynchronous serial line; idle high; 8N1 framing, LSB first.
REQ-005 Port: rx_data  output  8  received byte, held stable while rx_valid is high.
REQ-006 Port: rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-007 Port: rx_ready  input  1  consumer accepts the byte on any cycle where rx_valid && rx_ready.
REQ-008 Port: frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 Port: overrun  output  1  one-cycle pulse: completed byte dropped because the holding register was full.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer (output rx_s) before any use; both flops reset to 1.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP; the bit-timing counter SHALL be $clog2(CLKS_PER_BIT) bits wide and the bit index 3 bits wide.
REQ-012 IDLE: on a rx_s falling edge (previous 1, current 0), go to START and clear the counter; a line that is already low SHALL NOT trigger a start.
REQ-013 START: at counter == CLKS_PER_BIT/2-1 (mid-bit), sample rx_s; 0 -> DATA with counter and bit index cleared; 1 -> IDLE (glitch rejected, no outputs).
REQ-014 DATA: at counter == CLKS_PER_BIT-1, sample rx_s into the shift register MSB with a right shift, then increment the bit index; after bit index 7 -> STOP; otherwise stay in DATA.
REQ-015 STOP: at counter == CLKS_PER_BIT-1, sample rx_s; then go to IDLE.
REQ-016 Stop bit = 1: deliver the byte. Stop bit = 0: pulse frame_err on the next cycle and discard the byte.
REQ-017 Delivery with rx_valid == 0, or with rx_valid && rx_ready in the same cycle: load rx_data and set rx_valid on the next cycle.
REQ-018 Delivery with rx_valid == 1 and rx_ready == 0: leave rx_data and rx_valid unchanged and pulse overrun on the next cycle.
REQ-019 When rx_valid && rx_ready and no delivery occurs in that cycle, rx_valid SHALL clear on the next cycle.
REQ-020 Latency: rx_valid SHALL rise exactly 1 cycle after the stop-bit sample edge; the pin-to-sample delay SHALL include the 2 synchronizer cycles.
REQ-021 Bit timing SHALL restart on every start edge; no cumulative drift beyond one frame.
REQ-022 rx_ready SHALL have no effect on FSM progress; reception never stalls.

Reset
REQ-023 While rst_n == 0 at a clk edge: state = IDLE; counter, bit index, shift register and rx_data = 0; rx_valid, frame_err and overrun = 0; synchronizer flops = 1.
REQ-024 Reset asserted mid-frame SHALL abandon the frame with no delivery and no error pulse.
REQ-025 After reset release, the first start edge SHALL be detected only after rx_s has been observed high.

Structure
REQ-026 Package uart_pkg SHALL hold the state_t enum (IDLE, START, DATA, STOP, 2 bits) and the constant DATA_BITS = 8; the UART transmitter SHALL share this package.
REQ-027 The synchronizer SHALL be a sub-module named uart_sync (parameter STAGES = 2, reset value 1).

Verification
REQ-028 CLKS_PER_BIT=16, send 0x48 with rx_ready=0 -> rx_data = 0x48, rx_valid = 1 and held; raising rx_ready for 1 cycle -> rx_valid = 0 on the next cycle.
REQ-029 rx low for 4 cycles, then high -> no rx_valid, no frame_err; the FSM returns to IDLE; a following 0x21 is received correctly.
REQ-030 Send 0x55 with the stop bit forced 0 -> frame_err pulses exactly 1 cycle, rx_valid stays 0; hold rx low 40 cycles, then send 0x0A -> only 0x0A is delivered.
REQ-031 Send 0x41, then 0x42 back-to-back with rx_ready=0 -> rx_data stays 0x41 and overrun pulses once; with rx_ready=1 on the 0x42 delivery cycle, rx_data = 0x42 and no overrun.
REQ-032 Drive rst_n low for 1 cycle during bit 3 of 0x7E -> no delivery and no error; the next byte 0x0D is received as 0x0D.
REQ-033 Stream "Hello World!\n" (13 bytes, 1 stop bit each) with rx_ready=1 -> 13 rx_valid pulses carrying the exact byte sequence and no error pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states and data width, used by both RX and TX.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int unsigned DATA_BITS = 8;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous input; flops reset to the line's idle level (1).
module uart_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: synchronized line, mid-bit sampling, one-deep holding register
// with valid/ready hand-off, frame-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  logic             w_rx_s;
  logic             r_rx_prev;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_done;
  logic             r_ferr;

  uart_sync #(
    .STAGES(2)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (rx),
    .o_q  (w_rx_s)
  );

  // Previous-sample register resets low so a start edge needs rx_s seen high first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_prev <= 1'b0;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_rx_prev <= w_rx_s;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_rx_prev && !w_rx_s) begin
            r_state <= START;
            r_cnt   <= '0;
          end
        end
        START: begin
          if (r_cnt == CNT_MID) begin
            r_cnt <= '0;
            if (!w_rx_s) begin
              r_state   <= DATA;
              r_bit_idx <= '0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt     <= '0;
            r_shift   <= {w_rx_s, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == BIT_LAST) begin
              r_state <= STOP;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= IDLE;
            if (w_rx_s) begin
              r_done <= 1'b1;
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Holding register: a completed byte is taken only if the slot is empty or being drained.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= r_ferr;
      overrun   <= 1'b0;
      if (r_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= r_shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus queues expected events, a negedge monitor pops and compares.
module tb_uart_rx;

  localparam int unsigned CPB   = 16;
  localparam int unsigned FRAME = 10 * CPB;
  // Edge (counted from the first start-bit drive edge) at which a completed byte lands:
  // 2 sync flops + 1 edge detect, half-bit to start sample, 9 full bits to stop sample, +1 register.
  localparam int unsigned DELIV = 3 + CPB / 2 + 9 * CPB + 1;

  typedef enum logic [1:0] {EV_DATA, EV_FERR, EV_OVR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  uart_rx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, bench still running");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL monitor: got %s 0x%02h, expected no event", k.name(), d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (k == EV_DATA && e.data !== d)) begin
        n_err++;
        $display("FAIL monitor: got %s 0x%02h, expected %s 0x%02h",
                 k.name(), d, e.kind.name(), e.data);
      end
    end
  endtask

  // Monitor: every output event is matched against the head of the expectation queue.
  always @(negedge clk) begin
    if (frame_err) observe(EV_FERR, 8'h00);
    if (overrun) observe(EV_OVR, 8'h00);
    if (rx_valid && rx_ready) observe(EV_DATA, rx_data);
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      rx = 1'b1;
    end
  endtask

  task automatic hold_low(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      rx = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input bit pulse_ready, input bit chk_lat);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < int'(FRAME); i++) begin
      tick();
      rx = bits[i / CPB];
      if (pulse_ready) rx_ready = (i == int'(DELIV) - 1);
      if (chk_lat && i == int'(DELIV) - 1) check("latency_before", 32'(rx_valid), 32'd0);
      if (chk_lat && i == int'(DELIV)) check("latency_rise", 32'(rx_valid), 32'd1);
    end
  endtask

  task automatic consume();
    tick();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("valid_cleared", 32'(rx_valid), 32'd0);
  endtask

  initial begin
    string      msg;
    logic [9:0] bits;

    rst_n    = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b0;
    repeat (4) tick();
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    idle(20);

    // Single byte held until consumed, with exact delivery latency.
    send_frame(8'h48, 1'b1, 1'b0, 1'b1);
    idle(30);
    check("hold_valid_48", 32'(rx_valid), 32'd1);
    check("hold_data_48", 32'(rx_data), 32'h48);
    expect_ev(EV_DATA, 8'h48);
    consume();

    // Short low glitch is rejected, next byte still received.
    hold_low(4);
    idle(60);
    check("glitch_no_valid", 32'(rx_valid), 32'd0);
    expect_ev(EV_DATA, 8'h21);
    rx_ready = 1'b1;
    send_frame(8'h21, 1'b1, 1'b0, 1'b0);
    idle(20);
    rx_ready = 1'b0;

    // Bad stop bit, then a long low line that must not look like a start edge.
    expect_ev(EV_FERR, 8'h00);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    hold_low(40);
    check("ferr_no_valid", 32'(rx_valid), 32'd0);
    idle(32);
    expect_ev(EV_DATA, 8'h0A);
    rx_ready = 1'b1;
    send_frame(8'h0A, 1'b1, 1'b0, 1'b0);
    idle(20);
    rx_ready = 1'b0;

    // Back-to-back with a full holding register: second byte dropped, overrun once.
    expect_ev(EV_OVR, 8'h00);
    send_frame(8'h41, 1'b1, 1'b0, 1'b0);
    send_frame(8'h42, 1'b1, 1'b0, 1'b0);
    idle(20);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    check("ovr_data_kept", 32'(rx_data), 32'h41);
    expect_ev(EV_DATA, 8'h41);
    consume();

    // Drain on the delivery cycle itself: new byte replaces old, no overrun.
    expect_ev(EV_DATA, 8'h41);
    send_frame(8'h41, 1'b1, 1'b0, 1'b0);
    send_frame(8'h42, 1'b1, 1'b1, 1'b0);
    idle(20);
    check("swap_valid", 32'(rx_valid), 32'd1);
    check("swap_data", 32'(rx_data), 32'h42);
    expect_ev(EV_DATA, 8'h42);
    consume();

    // Reset in the middle of bit 3 of 0x7E abandons the frame.
    rx_ready = 1'b1;
    bits = {1'b1, 8'h7E, 1'b0};
    for (int i = 0; i < 3 * int'(CPB) + int'(CPB) + int'(CPB) / 2; i++) begin
      tick();
      rx = bits[i / CPB];
    end
    tick();
    rst_n = 1'b0;
    rx    = 1'b1;
    tick();
    rst_n = 1'b1;
    idle(200);
    check("rst_no_valid", 32'(rx_valid), 32'd0);
    check("rst_data_cleared", 32'(rx_data), 32'h00);
    expect_ev(EV_DATA, 8'h0D);
    send_frame(8'h0D, 1'b1, 1'b0, 1'b0);
    idle(20);

    // Continuous stream with the consumer always ready.
    msg = "Hello World!\n";
    check("stream_len", 32'(msg.len()), 32'd13);
    for (int i = 0; i < msg.len(); i++) begin
      expect_ev(EV_DATA, msg[i]);
      send_frame(msg[i], 1'b1, 1'b0, 1'b0);
    end
    idle(20);
    rx_ready = 1'b0;
    idle(10);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
